// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and op-class helpers for the multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [3:0] {
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } muldiv_op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
  function automatic logic is_signed(muldiv_op_t op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
  endfunction
  function automatic logic is_div(muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] d;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, shl;
  logic ge;
  // multiply: hi accumulates, lo shifts out multiplier bits; divide: hi is the partial remainder, lo shifts in quotient bits
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    shl = {hi, lo[WIDTH-1]};
    ge = shl >= {1'b0, d};
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      d <= '0;
      cnt <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= div ? a : b;
      d <= div ? b : a;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      hi <= div ? (ge ? shl[WIDTH-1:0] - d : shl[WIDTH-1:0]) : sum[WIDTH:1];
      lo <= div ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS-style HI/LO multiply, multiply-accumulate and divide unit.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  muldiv_op_t opc, op_q;
  state_t state, next;
  logic accept, mt, sgn, fin, sa, sb, dz, last;
  logic [WIDTH-1:0] a_mag, b_mag, p_hi, p_lo, q, r;
  logic [2*WIDTH-1:0] prod, res;
  assign opc = muldiv_op_t'(op);
  assign busy = state != S_IDLE;
  always_comb begin
    sgn = is_signed(opc);
    a_mag = sgn && a[WIDTH-1] ? -a : a;
    b_mag = sgn && b[WIDTH-1] ? -b : b;
    accept = start && !flush && state == S_IDLE && opc <= OP_DIVU;
    mt = start && !flush && state == S_IDLE && (opc == OP_MTHI || opc == OP_MTLO);
    fin = state == S_FINISH && !flush;
    // sa/sb are latched only for signed ops, so unsigned results pass through untouched
    prod = sa ^ sb ? -{p_hi, p_lo} : {p_hi, p_lo};
    q = sa ^ sb ? -p_lo : p_lo;
    r = sa ? -p_hi : p_hi;
    res = is_div(op_q) ? {r, q} :
          op_q inside {OP_MADD, OP_MADDU} ? {hi, lo} + prod :
          op_q inside {OP_MSUB, OP_MSUBU} ? {hi, lo} - prod : prod;
  end
  always_comb begin
    next = state;
    if (state == S_IDLE && accept) next = is_div(opc) && b == '0 ? S_FINISH : S_RUN;
    if (state == S_RUN && last) next = S_FINISH;
    if (state == S_FINISH) next = S_IDLE;
    if (flush) next = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_MULT;
      {sa, sb, dz, done, div_zero} <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= fin;
      div_zero <= fin && dz;
      if (accept) begin
        op_q <= opc;
        sa <= sgn && a[WIDTH-1];
        sb <= sgn && b[WIDTH-1];
        dz <= is_div(opc) && b == '0;
      end
      if (mt && opc == OP_MTHI) hi <= a;
      if (mt && opc == OP_MTLO) lo <= a;
      if (fin && !dz) {hi, lo} <= res;
    end
  end
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .run(state == S_RUN),
    .div(accept ? is_div(opc) : is_div(op_q)),
    .a(a_mag),
    .b(b_mag),
    .hi(p_hi),
    .lo(p_lo),
    .last(last)
  );
endmodule
